// File: rtl/genericIOSateliteEnv.sv
// Shared environment constants for the IO satellite blocks: reader FSM encodings
// and the legal event-width range.
package genericIOSateliteEnv;

    localparam logic [1:0] FSM_IDLE  = 2'd0;
    localparam logic [1:0] FSM_SHIFT = 2'd1;
    localparam logic [1:0] FSM_DONE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = FSM_IDLE,
        SHIFT = FSM_SHIFT,
        DONE  = FSM_DONE
    } readerState_t;

    localparam int unsigned EVENT_WIDTH_MIN = 2;
    localparam int unsigned EVENT_WIDTH_MAX = 32;

    // A serial bit moves only when both handshake sides agree in the same cycle.
    function automatic logic isTransfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/event_latch_clr.sv
// Sticky event register. A clear loads the same-cycle events instead of zero so
// nothing arriving during a snapshot is dropped.
module event_latch_clr #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             masterClk,
    input  logic             reset,
    input  logic [WIDTH-1:0] eventInput,
    input  logic             clr,
    output logic [WIDTH-1:0] pending
);

    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else if (clr) begin
            pending <= eventInput;
        end else begin
            pending <= pending | eventInput;
        end
    end

endmodule

// File: rtl/latch_reg_reader.sv
// Latches sticky event bits and, on request, snapshots and drains them as an
// MSB-first valid/ready serial frame followed by a one-cycle frameDone pulse.
module latch_reg_reader
    import genericIOSateliteEnv::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             masterClk,
    input  logic             reset,
    input  logic [WIDTH-1:0] eventInput,
    input  logic             readReq,
    output logic [WIDTH-1:0] pending,
    output logic             serialData,
    output logic             serialValid,
    input  logic             serialReady,
    output logic             busy,
    output logic             frameDone
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    readerState_t     state;
    logic [WIDTH-1:0] shiftReg;
    logic [CNT_W-1:0] bitCnt;
    logic             capture;
    logic             transfer;

    assign capture  = (state == IDLE) && readReq;
    assign transfer = isTransfer(serialValid, serialReady);

    event_latch_clr #(
        .WIDTH(WIDTH)
    ) uLatch (
        .masterClk (masterClk),
        .reset     (reset),
        .eventInput(eventInput),
        .clr       (capture),
        .pending   (pending)
    );

    // A full frame shifts out every loaded bit, so shiftReg is all-zero outside SHIFT.
    assign serialData = shiftReg[WIDTH-1];

    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shiftReg    <= '0;
            bitCnt      <= '0;
            serialValid <= 1'b0;
            busy        <= 1'b0;
            frameDone   <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (capture) begin
                        shiftReg    <= pending;
                        bitCnt      <= CNT_W'(WIDTH - 1);
                        serialValid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (transfer) begin
                        shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
                        if (bitCnt == '0) begin
                            serialValid <= 1'b0;
                            frameDone   <= 1'b1;
                            state       <= DONE;
                        end else begin
                            bitCnt <= bitCnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    shiftReg    <= '0;
                    bitCnt      <= '0;
                    serialValid <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_reg_reader.sv
// Self-checking bench for latch_reg_reader: directed table, corner-case sequences
// and a randomized run against a queue-based reference model.
module tb_latch_reg_reader;

    localparam int unsigned WIDTH = 32;

    logic             masterClk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] eventInput;
    logic             readReq;
    logic             serialReady;
    logic [WIDTH-1:0] pending;
    logic             serialData;
    logic             serialValid;
    logic             busy;
    logic             frameDone;

    int checks = 0;
    int errors = 0;

    latch_reg_reader #(.WIDTH(WIDTH)) dut (
        .masterClk  (masterClk),
        .reset      (reset),
        .eventInput (eventInput),
        .readReq    (readReq),
        .pending    (pending),
        .serialData (serialData),
        .serialValid(serialValid),
        .serialReady(serialReady),
        .busy       (busy),
        .frameDone  (frameDone)
    );

    always #5 masterClk = ~masterClk;

    // Reference model: sticky word, queue of bits still to send, done flag.
    logic [WIDTH-1:0] mPending;
    logic             mBits[$];
    logic             mDone;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelClear();
        mPending = '0;
        mBits.delete();
        mDone = 1'b0;
    endtask

    task automatic modelEdge();
        bit inFrame;
        bit idle;
        bit nextDone;
        inFrame  = (mBits.size() > 0);
        idle     = !inFrame && !mDone;
        nextDone = 1'b0;
        if (inFrame && serialReady) begin
            void'(mBits.pop_front());
            if (mBits.size() == 0) nextDone = 1'b1;
        end
        if (idle && readReq) begin
            for (int i = WIDTH - 1; i >= 0; i--) mBits.push_back(mPending[i]);
            mPending = eventInput;
        end else begin
            mPending = mPending | eventInput;
        end
        mDone = nextDone;
    endtask

    task automatic checkModel();
        logic expData;
        expData = (mBits.size() > 0) ? mBits[0] : 1'b0;
        check("model_pending", pending, mPending);
        check("model_valid", WIDTH'(serialValid), WIDTH'(mBits.size() > 0));
        check("model_data", WIDTH'(serialData), WIDTH'(expData));
        check("model_busy", WIDTH'(busy), WIDTH'((mBits.size() > 0) || mDone));
        check("model_done", WIDTH'(frameDone), WIDTH'(mDone));
    endtask

    // Called at a falling edge with inputs already driven.
    task automatic tick();
        @(posedge masterClk);
        modelEdge();
        @(negedge masterClk);
        checkModel();
    endtask

    task automatic applyReset();
        reset = 1'b1;
        #1;
        check("rst_pending", pending, '0);
        check("rst_valid", WIDTH'(serialValid), '0);
        check("rst_data", WIDTH'(serialData), '0);
        check("rst_busy", WIDTH'(busy), '0);
        check("rst_done", WIDTH'(frameDone), '0);
        modelClear();
        @(negedge masterClk);
        reset = 1'b0;
    endtask

    // Runs from the cycle after capture (capture tick counted as 1) until frameDone.
    task automatic runFrame(input bit toggle, input bit holdReq, output logic [WIDTH-1:0] word,
                            output int doneTick, output int validCycles, output int unstable);
        logic prevData;
        bit   prevStall;
        word = '0; doneTick = 0; validCycles = 0; unstable = 0;
        prevStall = 1'b0; prevData = 1'b0;
        readReq = holdReq; eventInput = '0; serialReady = 1'b1;
        for (int n = 2; n <= 300; n++) begin
            if (prevStall && serialData !== prevData) unstable++;
            if (serialValid) validCycles++;
            if (serialValid && serialReady) word = {word[WIDTH-2:0], serialData};
            prevStall = serialValid && !serialReady;
            prevData  = serialData;
            tick();
            if (frameDone) begin
                doneTick = n;
                break;
            end
            if (toggle) serialReady = ~serialReady;
        end
        readReq = 1'b0;
        check("frame_timeout", WIDTH'(doneTick != 0), WIDTH'(1));
    endtask

    typedef struct {
        logic [WIDTH-1:0] ev;
        logic             rr;
        logic             sr;
        logic [WIDTH-1:0] expPending;
        logic             expValid;
        logic             expData;
        logic             expBusy;
        logic             expDone;
    } vec_t;

    vec_t vecs[5];

    logic [WIDTH-1:0] word;
    int doneTick, validCycles, unstable, doneCount;

    initial begin
        reset = 1'b1; eventInput = '0; readReq = 1'b0; serialReady = 1'b0;
        modelClear();
        #1;
        check("por_pending", pending, '0);
        check("por_busy", WIDTH'(busy), '0);
        @(negedge masterClk);
        reset = 1'b0;

        // Idle after reset with no events.
        for (int i = 0; i < 3; i++) tick();
        check("idle_pending", pending, '0);
        check("idle_done", WIDTH'(frameDone), '0);

        // Directed table: event, capture, stall, one transfer, ignored request.
        vecs[0] = '{32'h8000_0001, 1'b0, 1'b1, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h0000_0010, 1'b0, 1'b0, 32'h0000_0010, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            eventInput = vecs[i].ev; readReq = vecs[i].rr; serialReady = vecs[i].sr;
            tick();
            check($sformatf("vec%0d_pending", i), pending, vecs[i].expPending);
            check($sformatf("vec%0d_valid", i), WIDTH'(serialValid), WIDTH'(vecs[i].expValid));
            check($sformatf("vec%0d_data", i), WIDTH'(serialData), WIDTH'(vecs[i].expData));
            check($sformatf("vec%0d_busy", i), WIDTH'(busy), WIDTH'(vecs[i].expBusy));
            check($sformatf("vec%0d_done", i), WIDTH'(frameDone), WIDTH'(vecs[i].expDone));
        end
        runFrame(1'b0, 1'b0, word, doneTick, validCycles, unstable);
        tick();

        // Single frame 8000_0001 with frameDone timing.
        applyReset();
        eventInput = 32'h8000_0001; readReq = 1'b0; serialReady = 1'b1;
        tick();
        eventInput = '0; readReq = 1'b1;
        tick();
        runFrame(1'b0, 1'b0, word, doneTick, validCycles, unstable);
        check("single_word", word, 32'h8000_0001);
        check("single_done_tick", WIDTH'(doneTick), WIDTH'(WIDTH + 1));
        tick();
        check("single_pending_after", pending, '0);
        check("single_idle_after", WIDTH'(busy), '0);

        // Event coinciding with the capture cycle stays for the next frame.
        eventInput = 32'h0000_0010;
        tick();
        eventInput = 32'h0000_0100; readReq = 1'b1;
        tick();
        check("capture_pending", pending, 32'h0000_0100);
        runFrame(1'b0, 1'b0, word, doneTick, validCycles, unstable);
        check("capture_word", word, 32'h0000_0010);
        tick();

        // Backpressure with serialReady toggling every cycle.
        applyReset();
        eventInput = 32'hA5A5_A5A5; serialReady = 1'b1;
        tick();
        eventInput = '0; readReq = 1'b1;
        tick();
        runFrame(1'b1, 1'b0, word, doneTick, validCycles, unstable);
        check("bp_word", word, 32'hA5A5_A5A5);
        check("bp_shift_cycles", WIDTH'(validCycles), WIDTH'(2 * WIDTH - 1));
        check("bp_unstable", WIDTH'(unstable), '0);
        tick();

        // readReq held through the frame starts no second frame.
        eventInput = 32'h1234_5678; readReq = 1'b0;
        tick();
        eventInput = '0; readReq = 1'b1;
        tick();
        runFrame(1'b0, 1'b1, word, doneTick, validCycles, unstable);
        check("ignored_word", word, 32'h1234_5678);
        tick();
        tick();
        check("ignored_no_second", WIDTH'(busy), '0);

        // Reset at bit 10 aborts the frame without frameDone.
        eventInput = 32'hFFFF_0000;
        tick();
        eventInput = '0; readReq = 1'b1; serialReady = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) tick();
        readReq = 1'b0;
        applyReset();
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (frameDone) doneCount++;
        end
        check("abort_no_done", WIDTH'(doneCount), '0);
        check("abort_pending", pending, '0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            eventInput  = WIDTH'($urandom & $urandom & $urandom);
            readReq     = ($urandom_range(0, 3) == 0);
            serialReady = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 399) == 0) applyReset();
            else tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/latch_reg_reader.md
LATCH_REG_READER -- requirements
Module: latch_reg_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the number of event bits latched and serialized per frame (legal range 2..32).
REQ-002 The block SHALL have port masterClk, input, 1, the single system clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous and active-high.
REQ-004 The block SHALL have port eventInput, input, WIDTH, raw event bits, where a high bit in any cycle sets the matching sticky bit.
REQ-005 The block SHALL have port readReq, input, 1, requesting a snapshot-and-drain frame; it is sampled only in IDLE.
REQ-006 The block SHALL have port pending, output, WIDTH, the current sticky register.
REQ-007 The block SHALL have port serialData, output, 1, the current frame bit, MSB first.
REQ-008 The block SHALL have port serialValid, output, 1, meaning serialData holds a valid bit.
REQ-009 The block SHALL have port serialReady, input, 1, the sink acceptance strobe; a bit transfers when serialValid and serialReady are both high.
REQ-010 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-011 The block SHALL have port frameDone, output, 1, a one-cycle pulse after the last bit transfers.

Function
REQ-012 pending SHALL update every cycle as pending | eventInput, except in a capture cycle (REQ-014).
REQ-013 The FSM SHALL have three states, IDLE, SHIFT and DONE, with no other reachable states.
REQ-014 Capture: at a clock edge in IDLE with readReq=1, the block SHALL load shiftReg <= pending, set pending <= eventInput, set bitCnt <= WIDTH-1 and go to SHIFT.
REQ-015 Capture boundary: an event present in the capture cycle SHALL NOT be lost; it SHALL remain in pending for the next frame.
REQ-016 In SHIFT, serialValid SHALL be 1 and serialData SHALL be shiftReg[WIDTH-1]; the first bit SHALL be valid in the cycle after readReq is accepted.
REQ-017 On each transfer, shiftReg SHALL shift left by one with 0 fill and bitCnt SHALL decrement.
REQ-018 Without a transfer, serialData and shiftReg SHALL stay stable.
REQ-019 A transfer at bitCnt=0 SHALL move the FSM to DONE.
REQ-020 DONE SHALL last exactly one cycle, with frameDone=1 and serialValid=0, then return to IDLE.
REQ-021 Outside SHIFT, serialValid SHALL be 0 and serialData SHALL be 0.
REQ-022 readReq SHALL be ignored while busy=1, with no queuing; readReq held high in IDLE SHALL start back-to-back frames.
REQ-023 Frame timing: with serialReady held at 1, a frame SHALL take WIDTH+1 cycles from capture to the frameDone cycle, and IDLE SHALL be re-entered at the following edge.
REQ-024 bitCnt SHALL be $clog2(WIDTH) bits wide and SHALL never wrap below 0.
REQ-025 Events arriving during SHIFT or DONE SHALL accumulate in pending and SHALL NOT alter the frame in flight.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE and clear pending, shiftReg and bitCnt to 0, and drive serialValid, serialData, busy and frameDone to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without a frameDone pulse, discarding the captured bits.
REQ-028 After reset deasserts, the first readReq SHALL be honoured no earlier than the next rising edge.

Structure
REQ-029 The FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL be defined as constants in the shared genericIOSateliteEnv include, not locally.
REQ-030 The sticky register with atomic capture-clear SHALL be a single sub-module, event_latch_clr (ports: masterClk, reset, eventInput, clr, pending), instantiated once.
REQ-031 The FSM, shift register and counter SHALL reside in latch_reg_reader.

Verification
REQ-032 Reset then idle: no events -> pending=32'h0, serialValid=0, busy=0, frameDone=0.
REQ-033 Single frame: pulse eventInput=32'h8000_0001 for one cycle, readReq for one cycle, serialReady=1 -> bits 1, then 30 zeros, then 1; frameDone pulses exactly 33 cycles after capture; pending=0 afterwards.
REQ-034 Simultaneous event at capture: pending=32'h0000_0010 and eventInput=32'h0000_0100 in the readReq cycle -> the frame carries 32'h0000_0010 and pending=32'h0000_0100 after capture.
REQ-035 Backpressure: toggle serialReady 1/0 every cycle with frame 32'hA5A5_A5A5 -> serialData stays stable while not ready, the received word equals 32'hA5A5_A5A5, and frameDone comes after 63 SHIFT cycles.
REQ-036 Ignored request and mid-frame reset: readReq asserted during SHIFT -> no second frame starts; reset asserted at bit 10 -> IDLE immediately, no frameDone, pending=0.
